// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, with a registered result and a done pulse.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 sgn_a, sgn_b, div0, ovf, special;
    logic [WIDTH-1:0]     mag_a, mag_b, spec_res;
    logic [WIDTH:0]       psum, shifted, trial;
    logic [2*WIDTH-1:0]   prod_nx, prod_s;
    logic [WIDTH-1:0]     rem_nx, quo_nx, dq, final_res;

    // Operand decode, special-case detection and one iteration of each datapath.
    always_comb begin
        sgn_a    = srcA[WIDTH-1] & (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
        sgn_b    = srcB[WIDTH-1] & (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
        mag_a    = sgn_a ? -srcA : srcA;
        mag_b    = sgn_b ? -srcB : srcB;
        div0     = funct3[2] & (srcB == '0);
        ovf      = funct3[2] & ~funct3[0] & (srcA == {1'b1, {(WIDTH-1){1'b0}}}) & (srcB == '1);
        special  = div0 | ovf;
        spec_res = div0 ? (funct3[1] ? srcA : '1) : (funct3[1] ? '0 : srcA);

        psum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        prod_nx  = {psum, acc_q[WIDTH-1:1]};
        prod_s   = neg_q ? -prod_nx : prod_nx;

        shifted  = {rem_q, acc_q[WIDTH-1]};
        trial    = shifted - {1'b0, b_q};
        rem_nx   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx   = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
        dq       = op_q[1] ? rem_nx : quo_nx;

        if (op_q[2])
            final_res = neg_q ? -dq : dq;
        else if (op_q[1:0] == 2'b00)
            final_res = prod_s[WIDTH-1:0];
        else
            final_res = prod_s[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (special) begin
                        result_d = spec_res;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNTW'(WIDTH);
                        op_d    = funct3;
                        neg_d   = (funct3[2] && funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
                        a_d     = mag_a;
                        b_d     = mag_b;
                        rem_d   = '0;
                        // Low half of acc holds the multiplier or the dividend.
                        acc_d   = {{WIDTH{1'b0}}, funct3[2] ? mag_a : mag_b};
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (op_q[2]) begin
                        acc_d = {{WIDTH{1'b0}}, quo_nx};
                        rem_d = rem_nx;
                    end else begin
                        acc_d = prod_nx;
                    end
                    if (cnt_q == CNTW'(1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed literal cases plus randomized
// traffic compared every cycle against a timeline model of the sequencer.
module tb_mdu_seq;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] srcA, srcB;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF));
    endfunction

    // Architectural RV32M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        bit ov;
        ov = (a == MINV) && (b == 32'hFFFF_FFFF);
        r = '0;
        case (f)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ov) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (ov) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    // Timeline model: m_left = cycles remaining until (and including) the done cycle.
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_result = '0;

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("done", {31'd0, done}, {31'd0, m_left == 1});
        chk("stall", {31'd0, stall}, {31'd0, (m_left == 0 && start && !flush) || m_left > 1});
        chk("result", result, m_result);
        if (reset) begin
            m_left   = 0;
            m_result = '0;
        end else if (m_left > 0) begin
            if (flush) m_left = 0;
            else m_left--;
        end else if (start && !flush) begin
            m_left = is_special(funct3, srcA, srcB) ? 1 : W + 1;
            m_pend = ref_op(funct3, srcA, srcB);
        end
        if (m_left == 1) m_result = m_pend;
    end

    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit hold,
                         input logic [31:0] exp_res, input int exp_k);
        int k;
        funct3 = f; srcA = a; srcB = b; start = 1'b1;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (!hold) start = 1'b0;
            if (done === 1'b1) break;
        end
        chk({nm, " done cycle"}, 32'(k), 32'(exp_k));
        chk({nm, " result"}, result, exp_res);
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " idle after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic abort_test(input string nm, input bit use_reset, input logic [31:0] exp_res);
        int k;
        funct3 = 3'd5; srcA = 32'd1000; srcB = 32'd7; start = 1'b1;
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk({nm, " no done"}, {31'd0, done}, 32'd0);
        end
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0;
        chk({nm, " busy c11"}, {31'd0, busy}, 32'd0);
        chk({nm, " stall c11"}, {31'd0, stall}, 32'd0);
        chk({nm, " done c11"}, {31'd0, done}, 32'd0);
        chk({nm, " result c11"}, result, exp_res);
        do_op({nm, " mul after"}, 3'd0, 32'd3, 32'd5, 1'b0, 32'd15, 33);
    endtask

    initial begin
        int dcnt, dc1, dc2;
        logic [31:0] r1, r2;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 33);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 33);
        do_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 33);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 33);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 33);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 33);
        do_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 33);
        do_op("remu", 3'd7, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0000_0001, 33);
        do_op("div by 0", 3'd4, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1);
        do_op("rem by 0", 3'd6, 32'd5, 32'd0, 1'b0, 32'd5, 1);
        do_op("div ovf", 3'd4, MINV, 32'hFFFF_FFFF, 1'b0, MINV, 1);
        do_op("rem ovf", 3'd6, MINV, 32'hFFFF_FFFF, 1'b0, 32'd0, 1);

        abort_test("flush", 1'b0, 32'd0);
        abort_test("reset", 1'b1, 32'd0);

        // Back-to-back muls with start held high.
        funct3 = 3'd0; srcA = 32'd6; srcB = 32'd7; start = 1'b1;
        dcnt = 0; dc1 = 0; dc2 = 0; r1 = '0; r2 = '0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (c == 33) begin srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF; end
            if (c == 35) begin
                chk("b2b second in CALC", {31'd0, busy & stall}, 32'd1);
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dcnt++;
                if (dcnt == 1) begin dc1 = c; r1 = result; end
                if (dcnt == 2) begin dc2 = c; r2 = result; end
            end
        end
        chk("b2b done count", 32'(dcnt), 32'd2);
        chk("b2b first cycle", 32'(dc1), 32'd33);
        chk("b2b second cycle", 32'(dc2), 32'd67);
        chk("b2b first result", r1, 32'd42);
        chk("b2b second result", r2, 32'd1);

        // Randomized traffic, checked by the per-cycle model.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            @(posedge clk); #1;
            reset  = ($urandom_range(0, 299) == 0);
            flush  = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 3) != 0);
            funct3 = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            srcA = (sel == 0) ? MINV : (sel < 4) ? 32'($urandom_range(0, 100)) : $urandom;
            sel = $urandom_range(0, 9);
            srcB = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
                   (sel < 4) ? 32'($urandom_range(1, 20)) : $urandom;
        end
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the Execute stage.
- Accepts one M-extension op from the decoder (funct7 = 0000001, with funct3 selecting the op).
- Runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles.
- Stalls the pipeline while busy and returns a registered result with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width; even, at least 4.
- CNTW, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, M-op valid in Execute; sampled only in IDLE.
- funct3, input, 3, op select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- srcA, input, WIDTH, rs1 operand (dividend / multiplicand).
- srcB, input, WIDTH, rs2 operand (divisor / multiplier).
- flush, input, 1, Execute-stage flush; aborts any op in flight.
- stall, output, 1, freeze F/D/E pipeline registers.
- busy, output, 1, state != IDLE.
- done, output, 1, one-cycle pulse; result valid in the same cycle.
- result, output, WIDTH, registered result; holds its value until the next done.

Behaviour:
- Reset (sync, highest priority):
  - state = IDLE; counter = 0; done = 0; result = 0; internal accumulators = 0.
  - Reset mid-op discards the op with no done pulse.
- FSM states are IDLE, CALC, DONE.
  - IDLE & start & special-case → DONE.
  - IDLE & start → CALC, with counter = WIDTH and the operands, funct3 and sign flags latched.
  - IDLE & !start → IDLE.
  - In CALC, counter decrements each cycle; at counter == 1 the next state is DONE and the final result is written.
  - DONE → IDLE unconditionally; start is ignored in DONE, since it still refers to the retiring instruction.
- Flush:
  - From CALC or DONE, flush forces IDLE next cycle and suppresses done; result keeps its old value.
  - flush & start in IDLE: no op is accepted.
- Latency:
  - Start in cycle 0 (IDLE) gives CALC in cycles 1..WIDTH and DONE in cycle WIDTH+1.
  - done = 1 only in cycle WIDTH+1.
  - Special cases: done in cycle 1.
- stall = (state==IDLE & start & !flush) | (state==CALC). It is low in DONE, so the pipeline advances on the DONE edge. A back-to-back M-op is then seen in IDLE the following cycle.
- Signed handling:
  - Signed operands: mul/mulh use A and B; mulhsu uses A only; div/rem use A and B.
  - Each signed operand is converted to its magnitude on latch and the core runs unsigned.
  - Product sign = sA^sB. Quotient sign = sA^sB. Remainder sign = sA.
  - The final negate is two's complement, applied on the write to result.
- Multiply:
  - Unsigned 2·WIDTH product accumulates LSB-first, one multiplier bit per cycle.
  - mul returns the low WIDTH bits; mulh, mulhsu and mulhu return the high WIDTH bits of the sign-corrected 2·WIDTH product.
- Divide:
  - Restoring divide, one quotient bit per cycle, MSB-first.
  - Partial remainder is WIDTH+1 bits wide so the trial subtract borrow is visible.
- Special cases (detected combinationally in IDLE):
  - Divide by zero (srcB == 0): div/divu → all ones; rem/remu → srcA.
  - Signed overflow (div/rem with srcA = 1<<(WIDTH-1) and srcB = all ones): div → srcA; rem → 0.
  - Multiply has no special cases.
- Outputs change only on clock edges, except stall, which is combinational.

Test Plan:
- Reset, then mul with srcA=7, srcB=0xFFFFFFFD, start held → stall high in cycles 0..32, done=1 only in cycle 33, result=0xFFFFFFEB, busy=0 in cycle 34.
- mulhu 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE. mulh same operands → 0x00000000. mulhsu srcA=0xFFFFFFFF, srcB=2 → 0xFFFFFFFF.
- Signed divide, srcA=0xFFFFFFF9 (−7), srcB=2: div → 0xFFFFFFFD (−3) and rem → 0xFFFFFFFF (−1). Unsigned same operands: divu → 0x7FFFFFFC, remu → 1. Each at cycle 33.
- Division special cases, each with done in cycle 1 and stall only in cycle 0:
  - div 5/0 → 0xFFFFFFFF.
  - rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem with the same operands → 0.
- Flush and reset mid-op:
  - Start divu, assert flush in cycle 10 → busy=0 and stall=0 in cycle 11, no done pulse, result unchanged.
  - A new mul then started in cycle 11 completes with done in cycle 44.
  - Repeat with reset in place of flush, and result = 0.
- Back-to-back: two muls with start continuously high → second op enters CALC in cycle 35, exactly two done pulses (cycles 33 and 67), correct results for both.
